cci_read_arbiter: RTL and testbench

CCI_READ_ARBITER -- requirements
Module: cci_read_arbiter

---
 rtl/cci_read_arbiter_pkg.sv | 23 ++
 rtl/cci_read_arbiter_if.sv | 27 ++
 rtl/cci_issue_holdoff.sv | 62 ++++++
 rtl/cci_read_arbiter.sv | 92 +++++++++
 tb/tb_cci_read_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cci_read_arbiter_pkg.sv
// Shared types and constants for the CCI TX0 read arbiter and its issue hold-off FSM.
package cci_read_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned REQ_STATUS = 0;
  localparam int unsigned REQ_READER = 1;
  localparam int unsigned REQ_WRITER = 2;
  localparam int unsigned OUT_W      = 7;
  localparam int unsigned HOLD_W     = 4;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [3:0]  req_type;
    logic [41:0] addr;
    logic [15:0] mdata;
  } tx_header_t;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_STALL = 1'b1
  } issue_state_e;

endpackage

// File: rtl/cci_read_arbiter_if.sv
// Requester-side and CCI TX0/RX0 read signals of the arbiter.
interface cci_read_arbiter_if;
  import cci_read_arbiter_pkg::*;

  logic [NUM_REQ-1:0] rd_req;
  tx_header_t         rd_hdr_status;
  tx_header_t         rd_hdr_reader;
  tx_header_t         rd_hdr_writer;
  logic [NUM_REQ-1:0] rd_grant;
  tx_header_t         tx0_header;
  logic               tx0_rdvalid;
  logic               tx0_almostfull;
  logic               rx0_rdvalid;

  modport slave (
    input  rd_req, rd_hdr_status, rd_hdr_reader, rd_hdr_writer,
    input  tx0_almostfull, rx0_rdvalid,
    output rd_grant, tx0_header, tx0_rdvalid
  );

  modport master (
    output rd_req, rd_hdr_status, rd_hdr_reader, rd_hdr_writer,
    output tx0_almostfull, rx0_rdvalid,
    input  rd_grant, tx0_header, tx0_rdvalid
  );

endinterface

// File: rtl/cci_issue_holdoff.sv
// Almost-full hold-off FSM: stalls issue on back-pressure and resumes only after
// AF_HOLDOFF consecutive low cycles of almostfull.
module cci_issue_holdoff
  import cci_read_arbiter_pkg::*;
#(
  parameter int unsigned AF_HOLDOFF = 4
) (
  input  logic clk,
  input  logic resetb,
  input  logic almostfull,
  output logic can_issue
);

  issue_state_e      state, state_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;

  // State register
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_ISSUE;
      hold_cnt <= '0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_cnt_next;
    end
  end

  // Next state; any almostfull high in STALL restarts the low-cycle count
  always_comb begin
    state_next    = state;
    hold_cnt_next = hold_cnt;
    case (state)
      ST_ISSUE: begin
        if (almostfull) begin
          state_next    = ST_STALL;
          hold_cnt_next = '0;
        end
      end
      ST_STALL: begin
        if (almostfull) begin
          hold_cnt_next = '0;
        end else if (hold_cnt + HOLD_W'(1) == HOLD_W'(AF_HOLDOFF)) begin
          state_next    = ST_ISSUE;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_next    = ST_ISSUE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Current almostfull suppresses issue in the very cycle it rises
  always_comb begin
    can_issue = 1'b0;
    if (state == ST_ISSUE && !almostfull) can_issue = 1'b1;
  end

endmodule

// File: rtl/cci_read_arbiter.sv
// TX0 read arbiter: status has strict priority, reader/writer share round-robin,
// issue gated by enable, almost-full hold-off and an outstanding-read credit limit.
module cci_read_arbiter
  import cci_read_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned AF_HOLDOFF      = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               afu_en,
  cci_read_arbiter_if.slave  bus,
  output logic [OUT_W-1:0]   outstanding,
  output logic               err_underflow
);

  logic               fsm_can_issue;
  logic               can_issue;
  logic               writer_next;
  logic               granted;
  logic [NUM_REQ-1:0] grant;
  tx_header_t         grant_hdr;

  cci_issue_holdoff #(.AF_HOLDOFF(AF_HOLDOFF)) u_holdoff (
    .clk        (clk),
    .resetb     (resetb),
    .almostfull (bus.tx0_almostfull),
    .can_issue  (fsm_can_issue)
  );

  assign can_issue = afu_en & fsm_can_issue & (outstanding < OUT_W'(MAX_OUTSTANDING));

  // Grant select: status first, then the reader/writer not granted most recently
  always_comb begin
    grant = '0;
    if (can_issue) begin
      if (bus.rd_req[REQ_STATUS]) begin
        grant[REQ_STATUS] = 1'b1;
      end else if (bus.rd_req[REQ_READER] && (!bus.rd_req[REQ_WRITER] || !writer_next)) begin
        grant[REQ_READER] = 1'b1;
      end else if (bus.rd_req[REQ_WRITER]) begin
        grant[REQ_WRITER] = 1'b1;
      end
    end
  end

  assign bus.rd_grant = grant;
  assign granted      = |grant;

  always_comb begin
    grant_hdr = bus.rd_hdr_status;
    if (grant[REQ_READER])      grant_hdr = bus.rd_hdr_reader;
    else if (grant[REQ_WRITER]) grant_hdr = bus.rd_hdr_writer;
  end

  // Round-robin pointer; status grants leave it alone, disable re-favours the reader
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb)                 writer_next <= 1'b0;
    else if (!afu_en)            writer_next <= 1'b0;
    else if (grant[REQ_READER])  writer_next <= 1'b1;
    else if (grant[REQ_WRITER])  writer_next <= 1'b0;
  end

  // Registered TX0 request; header holds when nothing is granted
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      bus.tx0_rdvalid <= 1'b0;
      bus.tx0_header  <= '0;
    end else begin
      bus.tx0_rdvalid <= granted;
      if (granted) bus.tx0_header <= grant_hdr;
    end
  end

  // In-flight accounting; a response with nothing outstanding is flagged, not counted
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      case ({granted, bus.rx0_rdvalid})
        2'b10: outstanding <= outstanding + OUT_W'(1);
        2'b01: begin
          if (outstanding == '0) err_underflow <= 1'b1;
          else                   outstanding   <= outstanding - OUT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cci_read_arbiter.sv
// Self-checking bench for cci_read_arbiter: vector table, directed corner sequences
// and randomized traffic against a cycle-level reference model.
module tb_cci_read_arbiter;
  import cci_read_arbiter_pkg::*;

  localparam int unsigned MAXO = 4;
  localparam int unsigned HOLD = 4;
  localparam logic [2:0] G_NONE = 3'b000;
  localparam logic [2:0] G_S    = 3'b001;
  localparam logic [2:0] G_R    = 3'b010;
  localparam logic [2:0] G_W    = 3'b100;

  logic       clk;
  logic       resetb;
  logic       afu_en;
  logic [6:0] outstanding;
  logic       err_underflow;

  cci_read_arbiter_if bus();

  cci_read_arbiter #(.MAX_OUTSTANDING(MAXO), .AF_HOLDOFF(HOLD)) dut (
    .clk           (clk),
    .resetb        (resetb),
    .afu_en        (afu_en),
    .bus           (bus),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model state
  int         m_out;
  bit         m_err;
  bit         m_valid;
  tx_header_t m_hdr;
  int         m_last_rw;    // 1 = reader granted last, 2 = writer (or none)
  int         m_last_high;  // cycle index of the most recent almostfull high
  logic [2:0] seen_grant;

  typedef struct {
    bit         en;
    logic [2:0] req;
    bit         af;
    bit         rx;
    logic [2:0] grant;
    int         out;
    bit         err;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_out       = 0;
    m_err       = 1'b0;
    m_valid     = 1'b0;
    m_hdr       = '0;
    m_last_rw   = 2;
    m_last_high = -1000;
  endtask

  // Issue is open when enabled, credits remain, and almostfull has been low this
  // cycle and in each of the previous HOLD cycles.
  function automatic logic [2:0] model_grant(input bit en, input logic [2:0] req, input bit af);
    bit open;
    open = en && !af && ((cyc - m_last_high) > int'(HOLD)) && (m_out < int'(MAXO));
    if (!open) return G_NONE;
    if (req[0]) return G_S;
    if (req[1] && req[2]) return (m_last_rw == 1) ? G_W : G_R;
    if (req[1]) return G_R;
    if (req[2]) return G_W;
    return G_NONE;
  endfunction

  // One clock cycle; entered and left at posedge + 1
  task automatic step(input bit en, input logic [2:0] req, input bit af, input bit rx);
    logic [2:0] g;
    tx_header_t hs, hr, hw;
    hs = {$urandom(), $urandom()};
    hr = {$urandom(), $urandom()};
    hw = {$urandom(), $urandom()};
    afu_en             = en;
    bus.rd_req         = req;
    bus.tx0_almostfull = af;
    bus.rx0_rdvalid    = rx;
    bus.rd_hdr_status  = hs;
    bus.rd_hdr_reader  = hr;
    bus.rd_hdr_writer  = hw;
    g = model_grant(en, req, af);
    @(negedge clk);
    seen_grant = bus.rd_grant;
    check("rd_grant", 64'(seen_grant), 64'(g));
    @(posedge clk);
    if (g != G_NONE) begin
      m_valid = 1'b1;
      m_hdr   = (g == G_S) ? hs : ((g == G_R) ? hr : hw);
    end else begin
      m_valid = 1'b0;
    end
    if (!en)            m_last_rw = 2;
    else if (g == G_R)  m_last_rw = 1;
    else if (g == G_W)  m_last_rw = 2;
    if (g != G_NONE && !rx) m_out++;
    else if (g == G_NONE && rx) begin
      if (m_out == 0) m_err = 1'b1;
      else            m_out--;
    end
    if (af) m_last_high = cyc;
    cyc++;
    #1;
    check("tx0_rdvalid", 64'(bus.tx0_rdvalid), 64'(m_valid));
    check("tx0_header", 64'(bus.tx0_header), 64'(m_hdr));
    check("outstanding", 64'(outstanding), 64'(m_out));
    check("err_underflow", 64'(err_underflow), 64'(m_err));
  endtask

  // Asynchronous reset pulse between clock edges, outputs checked before any edge
  task automatic do_reset();
    afu_en             = 1'b1;
    bus.rd_req         = '0;
    bus.tx0_almostfull = 1'b0;
    bus.rx0_rdvalid    = 1'b0;
    #2 resetb = 1'b0;
    #1;
    check("reset_rdvalid", 64'(bus.tx0_rdvalid), 64'(0));
    check("reset_outstanding", 64'(outstanding), 64'(0));
    check("reset_err", 64'(err_underflow), 64'(0));
    check("reset_header", 64'(bus.tx0_header), 64'(0));
    model_reset();
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'b110, 1'b0, 1'b0, G_R,    1, 1'b0};
    vecs[1]  = '{1'b1, 3'b110, 1'b0, 1'b0, G_W,    2, 1'b0};
    vecs[2]  = '{1'b1, 3'b111, 1'b0, 1'b0, G_S,    3, 1'b0};
    vecs[3]  = '{1'b1, 3'b110, 1'b0, 1'b1, G_R,    3, 1'b0};
    vecs[4]  = '{1'b1, 3'b100, 1'b0, 1'b0, G_W,    4, 1'b0};
    vecs[5]  = '{1'b1, 3'b110, 1'b0, 1'b0, G_NONE, 4, 1'b0};
    vecs[6]  = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 3, 1'b0};
    vecs[7]  = '{1'b1, 3'b010, 1'b0, 1'b0, G_R,    4, 1'b0};
    vecs[8]  = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 3, 1'b0};
    vecs[9]  = '{1'b0, 3'b110, 1'b0, 1'b0, G_NONE, 3, 1'b0};
    vecs[10] = '{1'b1, 3'b110, 1'b0, 1'b0, G_R,    4, 1'b0};
    vecs[11] = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 3, 1'b0};
    vecs[12] = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 2, 1'b0};
    vecs[13] = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 1, 1'b0};
    vecs[14] = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 0, 1'b0};
    vecs[15] = '{1'b1, 3'b000, 1'b0, 1'b1, G_NONE, 0, 1'b1};

    // Power-on reset
    resetb             = 1'b0;
    afu_en             = 1'b0;
    bus.rd_req         = '0;
    bus.tx0_almostfull = 1'b0;
    bus.rx0_rdvalid    = 1'b0;
    bus.rd_hdr_status  = '0;
    bus.rd_hdr_reader  = '0;
    bus.rd_hdr_writer  = '0;
    model_reset();
    #3;
    check("por_rdvalid", 64'(bus.tx0_rdvalid), 64'(0));
    check("por_outstanding", 64'(outstanding), 64'(0));
    check("por_err", 64'(err_underflow), 64'(0));
    check("por_header", 64'(bus.tx0_header), 64'(0));
    @(negedge clk);
    resetb = 1'b1;
    @(posedge clk);
    #1;

    // Vector table
    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].req, vecs[i].af, vecs[i].rx);
      check("vec_grant", 64'(seen_grant), 64'(vecs[i].grant));
      check("vec_outstanding", 64'(outstanding), 64'(vecs[i].out));
      check("vec_err", 64'(err_underflow), 64'(vecs[i].err));
    end

    // Reader/writer alternation starting with reader
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 3'b110, 1'b0, i > 0);
      check("alt_grant", 64'(seen_grant), 64'((i % 2 == 0) ? G_R : G_W));
      check("alt_valid", 64'(bus.tx0_rdvalid), 64'(1));
    end

    // Status priority leaves the round-robin pointer untouched
    do_reset();
    step(1'b1, 3'b111, 1'b0, 1'b0); check("prio_s0", 64'(seen_grant), 64'(G_S));
    step(1'b1, 3'b111, 1'b0, 1'b1); check("prio_s1", 64'(seen_grant), 64'(G_S));
    step(1'b1, 3'b111, 1'b0, 1'b1); check("prio_s2", 64'(seen_grant), 64'(G_S));
    step(1'b1, 3'b110, 1'b0, 1'b1); check("prio_r",  64'(seen_grant), 64'(G_R));
    step(1'b1, 3'b110, 1'b0, 1'b1); check("prio_w",  64'(seen_grant), 64'(G_W));
    step(1'b1, 3'b111, 1'b0, 1'b1); check("prio_s3", 64'(seen_grant), 64'(G_S));
    step(1'b1, 3'b110, 1'b0, 1'b1); check("prio_r2", 64'(seen_grant), 64'(G_R));

    // Almost-full hold-off, including a restart of the low-cycle count
    do_reset();
    step(1'b1, 3'b110, 1'b0, 1'b0); check("af_pre", 64'(seen_grant), 64'(G_R));
    step(1'b1, 3'b110, 1'b1, 1'b0); check("af_rise", 64'(seen_grant), 64'(G_NONE));
    for (int i = 0; i < int'(HOLD); i++) begin
      step(1'b1, 3'b110, 1'b0, 1'b0); check("af_hold", 64'(seen_grant), 64'(G_NONE));
    end
    step(1'b1, 3'b110, 1'b0, 1'b0); check("af_resume", 64'(seen_grant), 64'(G_W));
    step(1'b1, 3'b110, 1'b1, 1'b0); check("af_rise2", 64'(seen_grant), 64'(G_NONE));
    step(1'b1, 3'b110, 1'b0, 1'b0); check("af_low_a", 64'(seen_grant), 64'(G_NONE));
    step(1'b1, 3'b110, 1'b0, 1'b0); check("af_low_b", 64'(seen_grant), 64'(G_NONE));
    step(1'b1, 3'b110, 1'b1, 1'b0); check("af_restart", 64'(seen_grant), 64'(G_NONE));
    for (int i = 0; i < int'(HOLD); i++) begin
      step(1'b1, 3'b110, 1'b0, 1'b0); check("af_hold2", 64'(seen_grant), 64'(G_NONE));
    end
    step(1'b1, 3'b110, 1'b0, 1'b0); check("af_resume2", 64'(seen_grant), 64'(G_R));

    // Credit limit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 3'b010, 1'b0, 1'b0);
      check("cred_grant", 64'(seen_grant), 64'((i < int'(MAXO)) ? G_R : G_NONE));
    end
    check("cred_full", 64'(outstanding), 64'(MAXO));
    step(1'b1, 3'b010, 1'b0, 1'b1); check("cred_same_cycle", 64'(seen_grant), 64'(G_NONE));
    check("cred_freed", 64'(outstanding), 64'(MAXO - 1));
    step(1'b1, 3'b010, 1'b0, 1'b0); check("cred_next", 64'(seen_grant), 64'(G_R));
    check("cred_refull", 64'(outstanding), 64'(MAXO));

    // Simultaneous grant/response and underflow
    do_reset();
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b1); check("both_grant", 64'(seen_grant), 64'(G_R));
    check("both_out", 64'(outstanding), 64'(2));
    step(1'b1, 3'b000, 1'b0, 1'b1);
    step(1'b1, 3'b000, 1'b0, 1'b1); check("drain_out", 64'(outstanding), 64'(0));
    check("drain_err", 64'(err_underflow), 64'(0));
    step(1'b1, 3'b000, 1'b0, 1'b1); check("uf_out", 64'(outstanding), 64'(0));
    check("uf_err", 64'(err_underflow), 64'(1));
    step(1'b1, 3'b000, 1'b0, 1'b0); check("uf_sticky", 64'(err_underflow), 64'(1));

    // Mid-stream asynchronous reset
    do_reset();
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    step(1'b1, 3'b010, 1'b0, 1'b0);
    check("mid_out", 64'(outstanding), 64'(3));
    check("mid_valid", 64'(bus.tx0_rdvalid), 64'(1));
    do_reset();
    step(1'b1, 3'b110, 1'b0, 1'b0); check("post_reset_grant", 64'(seen_grant), 64'(G_R));

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, 3'($urandom()), $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
